// File: rtl/masked_gf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : masked_gf_pkg
//  Description : Shared constants and the GF(2^W) multiply helper used by the
//                masked multiplier pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package masked_gf_pkg;

   // Share count and number of refreshed cross-products per lane
   localparam int SHARES = 3;
   localparam int CROSS  = SHARES * SHARES;

   // Default field geometry (x^4 + x + 1, two lanes)
   localparam int         DEF_W     = 4;
   localparam int         DEF_LANES = 2;
   localparam logic [4:0] DEF_POLY  = 5'b10011;

   // Slice widths for the default geometry
   localparam int LANE_W  = DEF_W;
   localparam int LANE_RW = CROSS * DEF_W;

   // Carry-less multiply with on-the-fly reduction: a is shifted one bit per
   // step and reduced whenever its degree reaches w, so the result never
   // exceeds w bits. Callers cast the result down to their field width.
   function automatic logic [31:0] gf_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w,
                                          input logic [32:0] poly);
      logic [32:0] acc_a;
      logic [31:0] res;
      acc_a = {1'b0, a};
      res   = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) begin
            if (b[i]) res = res ^ acc_a[31:0];
            acc_a = acc_a << 1;
            if (acc_a[w[5:0]]) acc_a = acc_a ^ poly;
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/masked_gf_mult_lane.sv
`default_nettype none
// ============================================================================
//  Module      : masked_gf_mult_lane
//  Description : One 3-share masked GF(2^W) multiplier. Nine refreshed
//                cross-products are registered (P), then compressed per
//                output share into the y registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_gf_mult_lane
   import masked_gf_pkg::*;
#(
   parameter int         W    = 4,
   parameter logic [W:0] POLY = 5'b10011
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load_s1,
   input  logic               i_load_s2,
   input  logic [W-1:0]       i_a1,
   input  logic [W-1:0]       i_a2,
   input  logic [W-1:0]       i_a3,
   input  logic [W-1:0]       i_b1,
   input  logic [W-1:0]       i_b2,
   input  logic [W-1:0]       i_b3,
   input  logic [CROSS*W-1:0] i_r,
   output logic [W-1:0]       o_y1,
   output logic [W-1:0]       o_y2,
   output logic [W-1:0]       o_y3
);

   logic [W-1:0] w_a    [SHARES];
   logic [W-1:0] w_b    [SHARES];
   logic [W-1:0] w_term [CROSS];
   logic [W-1:0] r_p    [CROSS];
   logic [W-1:0] r_y    [SHARES];

   assign w_a[0] = i_a1;
   assign w_a[1] = i_a2;
   assign w_a[2] = i_a3;
   assign w_b[0] = i_b1;
   assign w_b[1] = i_b2;
   assign w_b[2] = i_b3;

   // Each mask r_n appears in exactly two terms (n and n-1 mod 9), so the
   // masks cancel in the overall XOR while every single P stays randomised.
   for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
      for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
         localparam int N  = SHARES * gi + gj;
         localparam int NN = (N + 1) % CROSS;
         assign w_term[N] = W'(gf_mul(32'(w_a[gi]), 32'(w_b[gj]), W, 33'(POLY)))
                            ^ i_r[N*W +: W] ^ i_r[NN*W +: W];
      end
   end

   // S1: capture the refreshed cross-products on accepted cycles only
   always_ff @(posedge clk) begin
      for (int n = 0; n < CROSS; n++) begin
         if (rst)            r_p[n] <= '0;
         else if (i_load_s1) r_p[n] <= w_term[n];
      end
   end

   // S2: compress each row of registered cross-products into one output share
   always_ff @(posedge clk) begin
      for (int i = 0; i < SHARES; i++) begin
         if (rst)            r_y[i] <= '0;
         else if (i_load_s2) r_y[i] <= r_p[SHARES*i] ^ r_p[SHARES*i+1] ^ r_p[SHARES*i+2];
      end
   end

   assign o_y1 = r_y[0];
   assign o_y2 = r_y[1];
   assign o_y3 = r_y[2];

endmodule
`default_nettype wire

// File: rtl/masked_gf_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : masked_gf_mult_pipe
//  Description : LANES independent 3-share masked GF(2^W) multipliers behind
//                a two-stage valid/ready pipeline with stall support.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_gf_mult_pipe
   import masked_gf_pkg::*;
#(
   parameter int         W     = 4,
   parameter logic [W:0] POLY  = 5'b10011,
   parameter int         LANES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*W-1:0]       a1,
   input  logic [LANES*W-1:0]       a2,
   input  logic [LANES*W-1:0]       a3,
   input  logic [LANES*W-1:0]       b1,
   input  logic [LANES*W-1:0]       b2,
   input  logic [LANES*W-1:0]       b3,
   input  logic [LANES*CROSS*W-1:0] r,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*W-1:0]       y1,
   output logic [LANES*W-1:0]       y2,
   output logic [LANES*W-1:0]       y3
);

   localparam int C_RW = CROSS * W;

   logic r_v1;
   logic r_v2;
   logic w_adv;
   logic w_accept;

   // The whole pipe moves when the output is consumed or the output slot is empty
   assign w_adv     = out_ready | ~r_v2;
   assign w_accept  = in_valid & w_adv;
   assign in_ready  = w_adv;
   assign out_valid = r_v2;

   // Stage valid bits; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (w_adv) begin
         r_v1 <= in_valid;
         r_v2 <= r_v1;
      end
   end

   for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      masked_gf_mult_lane #(
         .W    (W),
         .POLY (POLY)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .i_load_s1 (w_accept),
         .i_load_s2 (w_adv),
         .i_a1      (a1[gl*W +: W]),
         .i_a2      (a2[gl*W +: W]),
         .i_a3      (a3[gl*W +: W]),
         .i_b1      (b1[gl*W +: W]),
         .i_b2      (b2[gl*W +: W]),
         .i_b3      (b3[gl*W +: W]),
         .i_r       (r[gl*C_RW +: C_RW]),
         .o_y1      (y1[gl*W +: W]),
         .o_y2      (y2[gl*W +: W]),
         .o_y3      (y3[gl*W +: W])
      );
   end

endmodule
`default_nettype wire
